// File: rtl/forward_select_gen_pkg.sv
// Shared definitions for the operand-forwarding select generator.
// Holds the mux select encodings, tracking-stage indices and entry flag layout.
package forward_select_gen_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int FWD_SEL_W      = 2;

    // Tracking stages, nearest producer first.
    localparam int NUM_STG = 3;
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_RF     = 2'd0,
        FWD_EXMEM  = 2'd1,
        FWD_MEMWB  = 2'd2,
        FWD_WBHOLD = 2'd3
    } fwd_sel_e;

    // Per-entry flags; the destination field width is REG_ADDR_W.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } ent_flags_t;

endpackage

// File: rtl/forward_select_gen_fwd_match.sv
// Compares one source register against the EX/MEM/WB tracking entries and
// returns the select code of the nearest matching producer.
module fwd_match
    import forward_select_gen_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0]              src,
    input  logic [NUM_STG-1:0]                 valid,
    input  logic [NUM_STG-1:0]                 regwrite,
    input  logic [NUM_STG-1:0][REG_ADDR_W-1:0] dest,
    output logic [FWD_SEL_W-1:0]               sel
);

    logic [NUM_STG-1:0] hit;

    // $0 is hardwired, so a write to it is never a producer.
    for (genvar g = 0; g < NUM_STG; g++) begin : g_hit
        assign hit[g] = valid[g] && regwrite[g] && (dest[g] != '0) && (dest[g] == src);
    end

    always_comb begin
        sel = FWD_RF;
        if (hit[STG_EX])
            sel = FWD_EXMEM;
        else if (hit[STG_MEM])
            sel = FWD_MEMWB;
        else if (hit[STG_WB])
            sel = FWD_WBHOLD;
    end

endmodule

// File: rtl/forward_select_gen.sv
// Registered EX operand-forwarding selects plus combinational load-use stall.
// Define FWD_WB_HOLD_EN to track the WB entry and emit the post-WB hold code.
module forward_select_gen
    import forward_select_gen_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IdRs,
    input  logic [REG_ADDR_W-1:0] IdRt,
    input  logic                  IdUsesRt,
    input  logic                  IdRegWrite,
    input  logic                  IdMemRead,
    input  logic [REG_ADDR_W-1:0] IdWriteReg,
    input  logic                  Flush,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  Stall
);

    ent_flags_t            ex_f, mem_f;
    logic [REG_ADDR_W-1:0] ex_dest, mem_dest;
    logic                  wb_valid, wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_dest;

    logic [NUM_STG-1:0]                 stg_valid, stg_regwrite;
    logic [NUM_STG-1:0][REG_ADDR_W-1:0] stg_dest;
    logic [FWD_SEL_W-1:0]               sel_a, sel_b;
    logic [FWD_SEL_W-1:0]               fwd_a_nxt, fwd_b_nxt;
    logic                               load_use, bubble;
    ent_flags_t                         id_f;

    assign load_use = ex_f.valid && ex_f.memread && (ex_dest != '0) &&
                      ((ex_dest == IdRs) || (IdUsesRt && (ex_dest == IdRt)));
    assign Stall    = load_use && !Flush;
    assign bubble   = Stall || Flush;

    assign id_f = '{valid: 1'b1, regwrite: IdRegWrite, memread: IdMemRead};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_f     <= '0;
            mem_f    <= '0;
            ex_dest  <= '0;
            mem_dest <= '0;
            ForwardA <= FWD_RF;
            ForwardB <= FWD_RF;
        end else begin
            ex_f     <= bubble ? '0 : id_f;
            ex_dest  <= bubble ? '0 : IdWriteReg;
            mem_f    <= ex_f;
            mem_dest <= ex_dest;
            ForwardA <= fwd_a_nxt;
            ForwardB <= fwd_b_nxt;
        end
    end

`ifdef FWD_WB_HOLD_EN
    ent_flags_t wb_f;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wb_f    <= '0;
            wb_dest <= '0;
        end else begin
            wb_f    <= mem_f;
            wb_dest <= mem_dest;
        end
    end

    assign wb_valid    = wb_f.valid;
    assign wb_regwrite = wb_f.regwrite;

    // Load flags only matter while the producer sits in EX.
    logic unused_memread;
    assign unused_memread = ^{mem_f.memread, wb_f.memread};
`else
    // Without the hold path the register file must be write-first.
    assign wb_valid    = 1'b0;
    assign wb_regwrite = 1'b0;
    assign wb_dest     = '0;

    logic unused_memread;
    assign unused_memread = mem_f.memread;
`endif

    assign stg_valid    = {wb_valid,    mem_f.valid,    ex_f.valid};
    assign stg_regwrite = {wb_regwrite, mem_f.regwrite, ex_f.regwrite};
    assign stg_dest     = {wb_dest,     mem_dest,       ex_dest};

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
        .src      (IdRs),
        .valid    (stg_valid),
        .regwrite (stg_regwrite),
        .dest     (stg_dest),
        .sel      (sel_a)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
        .src      (IdRt),
        .valid    (stg_valid),
        .regwrite (stg_regwrite),
        .dest     (stg_dest),
        .sel      (sel_b)
    );

    // A bubble entering EX carries no forwarding.
    always_comb begin
        fwd_a_nxt = bubble ? FWD_RF : sel_a;
        fwd_b_nxt = (bubble || !IdUsesRt) ? FWD_RF : sel_b;
    end

endmodule

// File: tb/tb_forward_select_gen.sv
// Directed plus random checks of forward_select_gen against an age-ordered
// producer history model.
module tb_forward_select_gen;

    localparam int AW = 5;
`ifdef FWD_WB_HOLD_EN
    localparam int MDEPTH = 3;
`else
    localparam int MDEPTH = 2;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic [AW-1:0] IdRs, IdRt, IdWriteReg;
    logic          IdUsesRt, IdRegWrite, IdMemRead, Flush;
    logic [1:0]    ForwardA, ForwardB;
    logic          Stall;

    int   checks = 0;
    int   errors = 0;
    logic obs_stall;

    // History of instructions that entered EX; index 0 is the youngest.
    bit   hv[3], hrw[3], hmr[3];
    int   hd[3];

    forward_select_gen #(.REG_ADDR_W(AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IdRs       (IdRs),
        .IdRt       (IdRt),
        .IdUsesRt   (IdUsesRt),
        .IdRegWrite (IdRegWrite),
        .IdMemRead  (IdMemRead),
        .IdWriteReg (IdWriteReg),
        .Flush      (Flush),
        .ForwardA   (ForwardA),
        .ForwardB   (ForwardB),
        .Stall      (Stall)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input int src);
        for (int k = 0; k < MDEPTH; k++)
            if (hv[k] && hrw[k] && hd[k] != 0 && hd[k] == src)
                return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic logic m_stall(input int rs, input int rt, input bit ut, input bit fl);
        return !fl && hv[0] && hmr[0] && hd[0] != 0 && (hd[0] == rs || (ut && hd[0] == rt));
    endfunction

    task automatic step(input int rs, input int rt, input bit ut, input bit rw,
                        input bit mr, input int wr, input bit fl, input bit rst);
        logic       es;
        logic [1:0] ea, eb;
        IdRs = AW'(rs); IdRt = AW'(rt); IdUsesRt = ut; IdRegWrite = rw;
        IdMemRead = mr; IdWriteReg = AW'(wr); Flush = fl; Reset = rst;
        #1;
        obs_stall = Stall;
        es = m_stall(rs, rt, ut, fl);
        if (!rst) chk("stall", {1'b0, Stall}, {1'b0, es});
        if (rst) begin
            ea = 0; eb = 0;
            for (int k = 0; k < 3; k++) begin hv[k] = 0; hrw[k] = 0; hmr[k] = 0; hd[k] = 0; end
        end else begin
            ea = (es || fl) ? 2'd0 : m_fwd(rs);
            eb = (es || fl || !ut) ? 2'd0 : m_fwd(rt);
            for (int k = 2; k > 0; k--) begin
                hv[k] = hv[k-1]; hrw[k] = hrw[k-1]; hmr[k] = hmr[k-1]; hd[k] = hd[k-1];
            end
            hv[0] = !(es || fl); hrw[0] = rw; hmr[0] = mr; hd[0] = wr;
        end
        @(posedge Clk);
        #1;
        chk("fwd_a", ForwardA, ea);
        chk("fwd_b", ForwardB, eb);
    endtask

    initial begin
        // reset held for two cycles
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_fa", ForwardA, 2'd0);
        chk("rst_fb", ForwardB, 2'd0);
        IdRs = 1; IdRt = 2; IdUsesRt = 1; Flush = 0; Reset = 0;
        #1;
        chk("rst_stall", {1'b0, Stall}, 2'd0);

        // back-to-back ALU dependency
        step(1, 2, 1, 1, 0, 3, 0, 0);
        step(3, 0, 1, 1, 0, 8, 0, 0);
        chk("alu_b2b_fa", ForwardA, 2'd1);

        // producer two ahead on operand B
        step(0, 0, 0, 1, 0, 5, 0, 0);
        step(1, 2, 1, 1, 0, 9, 0, 0);
        step(0, 5, 1, 1, 0, 10, 0, 0);
        chk("two_ahead_fb", ForwardB, 2'd2);

        // load-use: one stall, bubble, then MEM/WB forward on re-issue
        step(1, 0, 0, 1, 1, 7, 0, 0);
        step(7, 0, 0, 1, 0, 11, 0, 0);
        chk("lduse_stall", {1'b0, obs_stall}, 2'd1);
        chk("lduse_bubble_fa", ForwardA, 2'd0);
        step(7, 0, 0, 1, 0, 11, 0, 0);
        chk("lduse_reissue_stall", {1'b0, obs_stall}, 2'd0);
        chk("lduse_reissue_fa", ForwardA, 2'd2);

        // $0 never forwarded; nearest of two writers wins
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 12, 0, 0);
        chk("r0_fa", ForwardA, 2'd0);
        chk("r0_fb", ForwardB, 2'd0);
        step(1, 1, 0, 1, 0, 4, 0, 0);
        step(1, 1, 0, 1, 0, 4, 0, 0);
        step(4, 4, 1, 1, 0, 13, 0, 0);
        chk("nearest_fa", ForwardA, 2'd1);
        chk("nearest_fb", ForwardB, 2'd1);

        // flush squashes forwarding and the squashed instruction itself
        step(1, 1, 0, 1, 0, 6, 0, 0);
        step(6, 6, 1, 1, 0, 14, 1, 0);
        chk("flush_stall", {1'b0, obs_stall}, 2'd0);
        chk("flush_fa", ForwardA, 2'd0);
        step(14, 14, 1, 1, 0, 15, 0, 0);
        chk("after_flush_fa", ForwardA, 2'd0);
        chk("after_flush_fb", ForwardB, 2'd0);

        // flush overrides a load-use stall
        step(1, 1, 0, 1, 1, 16, 0, 0);
        step(16, 0, 0, 1, 0, 17, 1, 0);
        chk("flush_lduse_stall", {1'b0, obs_stall}, 2'd0);

        // reset mid-stall leaves no stale entry
        step(1, 1, 0, 1, 1, 13, 0, 0);
        step(13, 0, 0, 1, 0, 18, 0, 1);
        step(13, 13, 1, 1, 0, 19, 0, 0);
        chk("rst_mid_stall", {1'b0, obs_stall}, 2'd0);
        chk("rst_mid_fa", ForwardA, 2'd0);

        // randomized traffic over a small register range to force hits
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
